// File: rtl/muntjac_fpu_pkg.sv
// Shared FPU types: rounding modes, accrued exception flags and the
// round-increment decision used by the rounding stage.
package muntjac_fpu_pkg;

    // RISC-V frm encoding.
    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } rounding_mode_e;

    // Ordered as the fflags CSR: {NV, DZ, OF, UF, NX}.
    typedef struct packed {
        logic invalid_operation;
        logic divide_by_zero;
        logic overflow;
        logic underflow;
        logic inexact;
    } exception_flags_t;

    // Decide whether the kept magnitude must be bumped by one LSB, given
    // the guard and sticky bits below it.
    function automatic logic round_increment(
        input rounding_mode_e mode,
        input logic           sign,
        input logic           lsb,
        input logic           guard,
        input logic           sticky
    );
        logic inc;
        case (mode)
            RNE:     inc = guard & (sticky | lsb);
            RTZ:     inc = 1'b0;
            RDN:     inc = sign & (guard | sticky);
            RUP:     inc = ~sign & (guard | sticky);
            RMM:     inc = guard;
            default: inc = 1'b0;
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/muntjac_fpu_right_shift.sv
// Logical right shifter that also reports whether any set bit fell off
// the bottom. Shift amounts of Width or more yield zero.
module muntjac_fpu_right_shift #(
    parameter int unsigned Width      = 25,
    parameter int unsigned ShAmtWidth = $clog2(Width + 1)
) (
    input  logic [Width-1:0]      data_i,
    input  logic [ShAmtWidth-1:0] shamt_i,
    output logic [Width-1:0]      data_o,
    output logic                  sticky_o
);

    logic [Width-1:0] lost_mask;

    // Shift and OR together every bit that the shift discards.
    always_comb begin
        data_o    = data_i >> shamt_i;
        lost_mask = ~({Width{1'b1}} << shamt_i);
        sticky_o  = |(data_i & lost_mask);
    end

endmodule

// File: rtl/muntjac_fpu_round_pack.sv
// Two-stage round-and-pack: stage 1 denormalises tiny values, stage 2
// rounds, detects overflow, applies specials and packs an IEEE word.
module muntjac_fpu_round_pack
    import muntjac_fpu_pkg::*;
#(
    parameter int unsigned ExpWidth   = 8,
    parameter int unsigned SigWidth   = 23,
    parameter int unsigned InExpWidth = 10
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  rounding_mode_e               req_rounding_mode_i,
    input  logic                         req_invalid_operation_i,
    input  logic                         req_sign_i,
    input  logic signed [InExpWidth-1:0] req_exponent_i,
    input  logic [SigWidth+1:0]          req_significand_i,
    input  logic                         req_is_zero_i,
    input  logic                         req_is_inf_i,
    input  logic                         req_is_nan_i,
    output logic                         resp_valid_o,
    input  logic                         resp_ready_i,
    output logic [ExpWidth+SigWidth:0]   resp_value_o,
    output exception_flags_t             resp_flags_o
);

    localparam int unsigned ShWidth    = SigWidth + 2;
    localparam int unsigned ShAmtWidth = $clog2(ShWidth + 1);
    localparam logic [InExpWidth:0] Bias   = (InExpWidth+1)'(2 ** (ExpWidth - 1) - 1);
    localparam logic [InExpWidth:0] MaxExp = (InExpWidth+1)'(2 ** ExpWidth - 1);
    localparam logic [InExpWidth:0] ShSat  = (InExpWidth+1)'(ShWidth);

    // Handshake
    logic v1_q, v1_d, v2_q, v2_d;
    logic stage1_ready, stage2_ready, s1_advance, s2_advance;

    // Stage 1 combinational
    logic [InExpWidth:0]   biased_exp, shift_dist;
    logic                  is_denorm;
    logic [ShAmtWidth-1:0] shamt;
    logic [ShWidth-1:0]    shifted;
    logic                  shifted_sticky;

    // Stage 1 registers
    logic                s1_sign_q, s1_sign_d;
    logic [InExpWidth:0] s1_exp_q, s1_exp_d;
    logic [SigWidth:0]   s1_mant_q, s1_mant_d;
    logic                s1_guard_q, s1_guard_d;
    logic                s1_sticky_q, s1_sticky_d;
    logic                s1_tiny_q, s1_tiny_d;
    rounding_mode_e      s1_mode_q, s1_mode_d;
    logic                s1_zero_q, s1_zero_d;
    logic                s1_inf_q, s1_inf_d;
    logic                s1_nan_q, s1_nan_d;
    logic                s1_nv_q, s1_nv_d;

    // Stage 2 combinational
    logic                round_up, overflow, inexact, ovf_to_inf;
    logic [SigWidth+1:0] rounded_sum;
    logic [InExpWidth:0] rounded_exp;

    // Stage 2 registers
    logic [ExpWidth+SigWidth:0] value_q, value_d;
    exception_flags_t           flags_q, flags_d;

    assign stage2_ready = ~v2_q | resp_ready_i;
    assign stage1_ready = ~v1_q | stage2_ready;
    assign req_ready_o  = stage1_ready;
    assign s1_advance   = req_valid_i & stage1_ready;
    assign s2_advance   = v1_q & stage2_ready;
    assign resp_valid_o = v2_q;
    assign resp_value_o = value_q;
    assign resp_flags_o = flags_q;

    // Valid bits move forward whenever the downstream slot is free.
    always_comb begin
        v1_d = stage1_ready ? req_valid_i : v1_q;
        v2_d = stage2_ready ? v1_q : v2_q;
    end

    // Bias the exponent and work out how far a tiny value must shift.
    always_comb begin
        biased_exp = {req_exponent_i[InExpWidth-1], req_exponent_i} + Bias;
        is_denorm  = biased_exp[InExpWidth] | (biased_exp == '0);
        shift_dist = (InExpWidth+1)'(1) - biased_exp;
        shamt      = (shift_dist > ShSat) ? ShAmtWidth'(ShWidth)
                                          : shift_dist[ShAmtWidth-1:0];
    end

    muntjac_fpu_right_shift #(
        .Width      (ShWidth),
        .ShAmtWidth (ShAmtWidth)
    ) u_denorm_shift (
        .data_i   ({1'b1, req_significand_i[SigWidth+1:1]}),
        .shamt_i  (shamt),
        .data_o   (shifted),
        .sticky_o (shifted_sticky)
    );

    // Stage 1 capture; tiny is decided here since it needs the unshifted bits.
    always_comb begin
        s1_sign_d   = s1_sign_q;
        s1_exp_d    = s1_exp_q;
        s1_mant_d   = s1_mant_q;
        s1_guard_d  = s1_guard_q;
        s1_sticky_d = s1_sticky_q;
        s1_tiny_d   = s1_tiny_q;
        s1_mode_d   = s1_mode_q;
        s1_zero_d   = s1_zero_q;
        s1_inf_d    = s1_inf_q;
        s1_nan_d    = s1_nan_q;
        s1_nv_d     = s1_nv_q;
        if (s1_advance) begin
            s1_sign_d = req_sign_i;
            s1_mode_d = req_rounding_mode_i;
            s1_zero_d = req_is_zero_i;
            s1_inf_d  = req_is_inf_i;
            s1_nan_d  = req_is_nan_i;
            s1_nv_d   = req_invalid_operation_i;
            if (is_denorm) begin
                s1_exp_d    = '0;
                s1_mant_d   = shifted[ShWidth-1:1];
                s1_guard_d  = shifted[0];
                s1_sticky_d = req_significand_i[0] | shifted_sticky;
            end else begin
                s1_exp_d    = biased_exp;
                s1_mant_d   = {1'b1, req_significand_i[SigWidth+1:2]};
                s1_guard_d  = req_significand_i[1];
                s1_sticky_d = req_significand_i[0];
            end
            // Just below the normal range, unbounded rounding may still carry
            // up to the smallest normal, which is then not tiny.
            s1_tiny_d = is_denorm &
                        ~((biased_exp == '0) &
                          (&req_significand_i[SigWidth+1:2]) &
                          round_increment(req_rounding_mode_i, req_sign_i,
                                          req_significand_i[2],
                                          req_significand_i[1],
                                          req_significand_i[0]));
        end
    end

    // Round, detect overflow, and pack the final word with its flags.
    always_comb begin
        round_up    = round_increment(s1_mode_q, s1_sign_q, s1_mant_q[0],
                                      s1_guard_q, s1_sticky_q);
        rounded_sum = {1'b0, s1_mant_q} + (SigWidth+2)'(round_up);
        rounded_exp = s1_exp_q + (InExpWidth+1)'(rounded_sum[SigWidth+1] |
                      ((s1_exp_q == '0) & rounded_sum[SigWidth]));
        overflow    = rounded_exp >= MaxExp;
        inexact     = s1_guard_q | s1_sticky_q;
        ovf_to_inf  = (s1_mode_q == RNE) | (s1_mode_q == RMM) |
                      ((s1_mode_q == RUP) & ~s1_sign_q) |
                      ((s1_mode_q == RDN) & s1_sign_q);
        value_d = value_q;
        flags_d = flags_q;
        if (s2_advance) begin
            flags_d = '0;
            flags_d.invalid_operation = s1_nv_q;
            if (s1_nan_q) begin
                value_d = {1'b0, {ExpWidth{1'b1}}, 1'b1, {(SigWidth-1){1'b0}}};
            end else if (s1_inf_q) begin
                value_d = {s1_sign_q, {ExpWidth{1'b1}}, {SigWidth{1'b0}}};
            end else if (s1_zero_q) begin
                value_d = {s1_sign_q, {(ExpWidth+SigWidth){1'b0}}};
            end else if (overflow) begin
                flags_d.overflow = 1'b1;
                flags_d.inexact  = 1'b1;
                value_d = ovf_to_inf
                        ? {s1_sign_q, {ExpWidth{1'b1}}, {SigWidth{1'b0}}}
                        : {s1_sign_q, {(ExpWidth-1){1'b1}}, 1'b0, {SigWidth{1'b1}}};
            end else begin
                flags_d.inexact   = inexact;
                flags_d.underflow = s1_tiny_q & inexact;
                value_d = {s1_sign_q, rounded_exp[ExpWidth-1:0],
                           rounded_sum[SigWidth-1:0]};
            end
        end
    end

    // Pipeline state; everything clears on reset so nothing in flight survives.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_exp_q    <= '0;
            s1_mant_q   <= '0;
            s1_guard_q  <= 1'b0;
            s1_sticky_q <= 1'b0;
            s1_tiny_q   <= 1'b0;
            s1_mode_q   <= RNE;
            s1_zero_q   <= 1'b0;
            s1_inf_q    <= 1'b0;
            s1_nan_q    <= 1'b0;
            s1_nv_q     <= 1'b0;
            value_q     <= '0;
            flags_q     <= '0;
        end else begin
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            s1_sign_q   <= s1_sign_d;
            s1_exp_q    <= s1_exp_d;
            s1_mant_q   <= s1_mant_d;
            s1_guard_q  <= s1_guard_d;
            s1_sticky_q <= s1_sticky_d;
            s1_tiny_q   <= s1_tiny_d;
            s1_mode_q   <= s1_mode_d;
            s1_zero_q   <= s1_zero_d;
            s1_inf_q    <= s1_inf_d;
            s1_nan_q    <= s1_nan_d;
            s1_nv_q     <= s1_nv_d;
            value_q     <= value_d;
            flags_q     <= flags_d;
        end
    end

endmodule

// File: tb/tb_muntjac_fpu_round_pack.sv
// Self-checking bench for muntjac_fpu_round_pack (single precision).
module tb_muntjac_fpu_round_pack;
    import muntjac_fpu_pkg::*;

    localparam logic [4:0] FlagNv = 5'b10000;
    localparam logic [4:0] FlagOf = 5'b00100;
    localparam logic [4:0] FlagUf = 5'b00010;
    localparam logic [4:0] FlagNx = 5'b00001;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              req_valid_i;
    logic              req_ready_o;
    rounding_mode_e    req_rounding_mode_i;
    logic              req_invalid_operation_i;
    logic              req_sign_i;
    logic signed [9:0] req_exponent_i;
    logic [24:0]       req_significand_i;
    logic              req_is_zero_i, req_is_inf_i, req_is_nan_i;
    logic              resp_valid_o;
    logic              resp_ready_i;
    logic [31:0]       resp_value_o;
    exception_flags_t  resp_flags_o;

    int checks = 0;
    int failures = 0;

    // Handshake test storage
    int             hs_exp[4];
    logic [24:0]    hs_sig[4];
    rounding_mode_e hs_mode[4];
    logic           hs_sign[4];
    logic [36:0]    hs_expect[4];

    // Random test scratch
    rounding_mode_e r_mode;
    logic           r_sign, r_nv, r_zero, r_inf, r_nan, acc, got;
    int             r_exp, r_sel, sent, recv;
    logic [24:0]    r_sig;
    logic [36:0]    r_expect;

    always #5 clk_i = ~clk_i;

    muntjac_fpu_round_pack dut (
        .clk_i                   (clk_i),
        .rst_ni                  (rst_ni),
        .req_valid_i             (req_valid_i),
        .req_ready_o             (req_ready_o),
        .req_rounding_mode_i     (req_rounding_mode_i),
        .req_invalid_operation_i (req_invalid_operation_i),
        .req_sign_i              (req_sign_i),
        .req_exponent_i          (req_exponent_i),
        .req_significand_i       (req_significand_i),
        .req_is_zero_i           (req_is_zero_i),
        .req_is_inf_i            (req_is_inf_i),
        .req_is_nan_i            (req_is_nan_i),
        .resp_valid_o            (resp_valid_o),
        .resp_ready_i            (resp_ready_i),
        .resp_value_o            (resp_value_o),
        .resp_flags_o            (resp_flags_o)
    );

    // Round-up decision from the discarded remainder r against half a quantum.
    function automatic logic roundUp(input rounding_mode_e mode, input logic sign,
                                     input logic lsb, input longint r, input longint half);
        case (mode)
            RNE:     return (r > half) || (r == half && lsb);
            RTZ:     return 1'b0;
            RDN:     return sign && (r != 0);
            RUP:     return !sign && (r != 0);
            RMM:     return r >= half;
            default: return 1'b0;
        endcase
    endfunction

    // Numeric reference: value is m * 2^(e-25) with m = (2^25 | sig); returns {flags, word}.
    function automatic logic [36:0] refModel(input rounding_mode_e mode, input logic nv,
                                             input logic sign, input int e, input logic [24:0] sig,
                                             input logic zero, input logic inf, input logic nan);
        longint m, trunc, r, half, t, frac, tu;
        int     eq, k, biased, eu;
        logic   up, inexact, tiny;
        logic [4:0]  flags;
        logic [31:0] value;
        flags = nv ? FlagNv : 5'b0;
        if (nan)  return {flags, 32'h7FC00000};
        if (inf)  return {flags, sign, 8'hFF, 23'h0};
        if (zero) return {flags, sign, 31'h0};
        m     = (longint'(1) << 25) | longint'(sig);
        eq    = (e > -126) ? e : -126;
        k     = eq - e + 2;
        if (k > 30) k = 30;
        trunc = m >> k;
        r     = m & ((longint'(1) << k) - 1);
        half  = longint'(1) << (k - 1);
        up    = roundUp(mode, sign, trunc[0], r, half);
        t     = trunc + longint'(up);
        if (e >= -126) begin
            if (t == (longint'(1) << 24)) begin biased = e + 128; frac = 0; end
            else begin biased = e + 127; frac = t - (longint'(1) << 23); end
        end else begin
            if (t >= (longint'(1) << 23)) begin biased = 1; frac = t - (longint'(1) << 23); end
            else begin biased = 0; frac = t; end
        end
        inexact = (r != 0);
        tu   = (m >> 2) + longint'(roundUp(mode, sign, m[2], m & 3, 2));
        eu   = (tu == (longint'(1) << 24)) ? e + 1 : e;
        tiny = (eu + 127) < 1;
        if (biased >= 255) begin
            flags = flags | FlagOf | FlagNx;
            if (mode == RNE || mode == RMM || (mode == RUP && !sign) || (mode == RDN && sign))
                value = {sign, 8'hFF, 23'h0};
            else
                value = {sign, 8'hFE, 23'h7FFFFF};
        end else begin
            if (inexact) flags = flags | FlagNx;
            if (inexact && tiny) flags = flags | FlagUf;
            value = {sign, biased[7:0], frac[22:0]};
        end
        return {flags, value};
    endfunction

    task automatic stepCycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic driveReq(input rounding_mode_e mode, input logic nv, input logic sign,
                            input int e, input logic [24:0] sig,
                            input logic zero, input logic inf, input logic nan);
        req_rounding_mode_i     = mode;
        req_invalid_operation_i = nv;
        req_sign_i              = sign;
        req_exponent_i          = e[9:0];
        req_significand_i       = sig;
        req_is_zero_i           = zero;
        req_is_inf_i            = inf;
        req_is_nan_i            = nan;
    endtask

    // Present one request and wait (bounded) for the accepting edge.
    task automatic applyStimulus(input rounding_mode_e mode, input logic nv, input logic sign,
                                 input int e, input logic [24:0] sig,
                                 input logic zero, input logic inf, input logic nan);
        logic accepted;
        driveReq(mode, nv, sign, e, sig, zero, inf, nan);
        req_valid_i = 1'b1;
        accepted = 1'b0;
        for (int c = 0; c < 20 && !accepted; c++) begin
            accepted = req_ready_o;
            stepCycle();
        end
        req_valid_i = 1'b0;
        checkOutput("accept", 32'(accepted), 32'd1);
    endtask

    // One isolated transaction: checks latency, value and flags.
    task automatic runSingle(input string tag, input rounding_mode_e mode, input logic nv,
                             input logic sign, input int e, input logic [24:0] sig,
                             input logic zero, input logic inf, input logic nan,
                             input logic [31:0] exp_value, input logic [4:0] exp_flags);
        resp_ready_i = 1'b1;
        applyStimulus(mode, nv, sign, e, sig, zero, inf, nan);
        checkOutput({tag, "_lat1"}, 32'(resp_valid_o), 32'd0);
        stepCycle();
        checkOutput({tag, "_valid"}, 32'(resp_valid_o), 32'd1);
        checkOutput({tag, "_value"}, resp_value_o, exp_value);
        checkOutput({tag, "_flags"}, 32'(resp_flags_o), 32'(exp_flags));
        stepCycle();
    endtask

    initial begin
        rst_ni       = 1'b0;
        req_valid_i  = 1'b0;
        resp_ready_i = 1'b1;
        driveReq(RNE, 1'b0, 1'b0, 0, 25'h0, 1'b0, 1'b0, 1'b0);
        #12;
        checkOutput("rst_valid", 32'(resp_valid_o), 32'd0);
        checkOutput("rst_value", resp_value_o, 32'h0);
        checkOutput("rst_flags", 32'(resp_flags_o), 32'h0);
        checkOutput("rst_ready", 32'(req_ready_o), 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        stepCycle();

        runSingle("one",      RNE, 0, 0,    0, 25'h0,       0, 0, 0, 32'h3F800000, 5'b0);
        runSingle("rne_up",   RNE, 0, 0,    0, 25'h0000006, 0, 0, 0, 32'h3F800002, FlagNx);
        runSingle("rtz",      RTZ, 0, 0,    0, 25'h0000006, 0, 0, 0, 32'h3F800001, FlagNx);
        runSingle("rne_tie",  RNE, 0, 0,    0, 25'h0000002, 0, 0, 0, 32'h3F800000, FlagNx);
        runSingle("ovf_rne",  RNE, 0, 0,  128, 25'h0,       0, 0, 0, 32'h7F800000, FlagOf | FlagNx);
        runSingle("ovf_rtz",  RTZ, 0, 0,  128, 25'h0,       0, 0, 0, 32'h7F7FFFFF, FlagOf | FlagNx);
        runSingle("ovf_rup",  RUP, 0, 1,  128, 25'h0,       0, 0, 0, 32'hFF7FFFFF, FlagOf | FlagNx);
        runSingle("ovf_carry",RNE, 0, 0,  127, 25'h1FFFFFE, 0, 0, 0, 32'h7F800000, FlagOf | FlagNx);
        runSingle("sub_half", RNE, 0, 0, -127, 25'h0,       0, 0, 0, 32'h00400000, 5'b0);
        runSingle("sub_rne",  RNE, 0, 0, -150, 25'h0,       0, 0, 0, 32'h00000000, FlagUf | FlagNx);
        runSingle("sub_rup",  RUP, 0, 0, -150, 25'h0,       0, 0, 0, 32'h00000001, FlagUf | FlagNx);
        runSingle("nan",      RNE, 1, 1,    5, 25'h123,     0, 0, 1, 32'h7FC00000, FlagNv);
        runSingle("inf",      RNE, 0, 1,    0, 25'h0,       0, 1, 0, 32'hFF800000, 5'b0);
        runSingle("zero",     RNE, 0, 1,    0, 25'h0,       1, 0, 0, 32'h80000000, 5'b0);

        // Stream four requests into a stalled output.
        for (int i = 0; i < 4; i++) begin
            hs_exp[i]    = int'($urandom_range(0, 40)) - 20;
            hs_sig[i]    = 25'($urandom);
            hs_mode[i]   = rounding_mode_e'(3'($urandom_range(0, 4)));
            hs_sign[i]   = 1'($urandom);
            hs_expect[i] = refModel(hs_mode[i], 1'b0, hs_sign[i], hs_exp[i], hs_sig[i], 0, 0, 0);
        end
        resp_ready_i = 1'b0;
        sent = 0;
        recv = 0;
        for (int c = 0; c < 5; c++) begin
            driveReq(hs_mode[sent], 1'b0, hs_sign[sent], hs_exp[sent], hs_sig[sent], 0, 0, 0);
            req_valid_i = 1'b1;
            acc = req_ready_o;
            stepCycle();
            if (acc) sent++;
            if (c >= 1) begin
                checkOutput("hs_stall_valid", 32'(resp_valid_o), 32'd1);
                checkOutput("hs_stall_value", resp_value_o, hs_expect[0][31:0]);
                checkOutput("hs_stall_flags", 32'(resp_flags_o), 32'(hs_expect[0][36:32]));
            end
        end
        checkOutput("hs_accepted", 32'(sent), 32'd2);
        checkOutput("hs_ready_low", 32'(req_ready_o), 32'd0);
        resp_ready_i = 1'b1;
        #1;
        checkOutput("hs_ready_comb", 32'(req_ready_o), 32'd1);
        for (int c = 0; c < 30 && recv < 4; c++) begin
            if (sent < 4) begin
                driveReq(hs_mode[sent], 1'b0, hs_sign[sent], hs_exp[sent], hs_sig[sent], 0, 0, 0);
                req_valid_i = 1'b1;
            end else begin
                req_valid_i = 1'b0;
            end
            acc = req_valid_i & req_ready_o;
            got = resp_valid_o & resp_ready_i;
            if (got) begin
                checkOutput("hs_value", resp_value_o, hs_expect[recv][31:0]);
                checkOutput("hs_flags", 32'(resp_flags_o), 32'(hs_expect[recv][36:32]));
                recv++;
            end
            stepCycle();
            if (acc) sent++;
        end
        req_valid_i = 1'b0;
        checkOutput("hs_recv_count", 32'(recv), 32'd4);
        checkOutput("hs_no_dup", 32'(resp_valid_o), 32'd0);

        // Reset with two results in flight.
        resp_ready_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            driveReq(RNE, 1'b0, 1'b0, c, 25'h4, 0, 0, 0);
            req_valid_i = 1'b1;
            stepCycle();
        end
        req_valid_i = 1'b0;
        checkOutput("rst_inflight_full", 32'(resp_valid_o), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("rst_mid_valid", 32'(resp_valid_o), 32'd0);
        checkOutput("rst_mid_value", resp_value_o, 32'h0);
        checkOutput("rst_mid_ready", 32'(req_ready_o), 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        resp_ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            stepCycle();
            checkOutput("rst_no_stale", 32'(resp_valid_o), 32'd0);
        end

        // Randomised transactions against the numeric model.
        for (int n = 0; n < 40; n++) begin
            r_mode = rounding_mode_e'(3'($urandom_range(0, 4)));
            r_sign = 1'($urandom);
            r_nv   = 1'($urandom);
            r_exp  = int'($urandom_range(0, 290)) - 160;
            r_sig  = 25'($urandom);
            r_sel  = int'($urandom_range(0, 9));
            r_nan  = (r_sel == 0);
            r_inf  = (r_sel == 1);
            r_zero = (r_sel == 2);
            r_expect = refModel(r_mode, r_nv, r_sign, r_exp, r_sig, r_zero, r_inf, r_nan);
            runSingle("rand", r_mode, r_nv, r_sign, r_exp, r_sig, r_zero, r_inf, r_nan,
                      r_expect[31:0], r_expect[36:32]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muntjac_fpu_round_pack.md
# muntjac_fpu_round_pack

Pipelined rounding and packing stage for the FPU. It consumes an unrounded, unpacked result (sign, signed unbiased exponent, fraction with guard and sticky bits, special flags), the same form the add, mul and fma datapaths emit. It applies the dynamic rounding mode, handles subnormal denormalisation, overflow and the RISC-V canonical NaN, and emits an IEEE-754 packed word with accrued exception flags. It sits between the arithmetic units and the FP register-file writeback, with a valid/ready handshake on both sides.

## Interface
- ExpWidth, 8: packed exponent field width.
- SigWidth, 23: packed fraction field width.
- InExpWidth, 10: signed unbiased input exponent width. Must be at least ExpWidth+2.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  input valid.
- req_ready_o  out  1  input ready.
- req_rounding_mode_i  in  muntjac_fpu_pkg::rounding_mode_e  rounding mode.
- req_invalid_operation_i  in  1  NV from the producing unit.
- req_sign_i  in  1  sign.
- req_exponent_i  in  signed [InExpWidth-1:0]  unbiased exponent. Value is 1.frac × 2^exp.
- req_significand_i  in  [SigWidth+1:0]  {fraction (hidden 1 excluded), guard bit, sticky bit}.
- req_is_zero_i, req_is_inf_i, req_is_nan_i  in  1 each  special-value flags.
- resp_valid_o  out  1  output valid.
- resp_ready_i  in  1  output ready.
- resp_value_o  out  [ExpWidth+SigWidth:0]  packed IEEE result.
- resp_flags_o  out  muntjac_fpu_pkg::exception_flags_t  {NV, DZ, OF, UF, NX}. DZ is always 0.

## Operation
- Bias = 2^(ExpWidth-1)-1. Biased exponent be = exp + bias, computed at InExpWidth+1 bits signed.
- Stage 1 (denormalise):
  - be ≥ 1: the significand passes unchanged.
  - be < 1: right-shift {1, frac, guard} by 1-be, saturating at SigWidth+2. All shifted-out bits OR into sticky, and the working exponent becomes 0.
  - Register {sign, working exponent, shifted significand, round/sticky, mode, specials, NV}.
- Stage 2 (round and pack):
  - Compute the increment from LSB, guard (g) and sticky (s):
    - RNE: g&(s|lsb).
    - RTZ: 0.
    - RDN: sign&(g|s).
    - RUP: !sign&(g|s).
    - RMM: g.
  - The fraction+1 carry propagates into the exponent. For a subnormal, a carry into the hidden bit yields exponent 1.
  - Overflow: be ≥ 2^ExpWidth-1 after rounding.
    - RNE, RMM, and the mode whose direction matches the sign (RUP for positive, RDN for negative): result is ±inf.
    - Otherwise: result is ±max-finite.
    - Set OF and NX.
  - NX = g|s, or overflow.
  - UF = tiny-after-rounding & NX, where tiny means the result rounded as if the exponent were unbounded is still below 2^(1-bias).
- Specials override stage-2 arithmetic and raise no OF, UF or NX:
  - NaN: canonical NaN (exponent all-ones, fraction MSB only, sign 0).
  - inf: ±inf.
  - zero: ±0 with the input sign.
- NV passes straight through from req_invalid_operation_i.

## Timing
- Latency: 2 cycles from accepted request to resp_valid_o. Throughput 1 per cycle.
- Per-stage valid bits, stall-propagating ready:
  - stage2_ready = !v2 | resp_ready_i.
  - stage1_ready = !v1 | stage2_ready.
  - req_ready_o = stage1_ready.
- A stage's data registers load only when that stage advances. Outputs hold stable while resp_valid_o & !resp_ready_i.
- No combinational path from req_valid_i to resp_valid_o. The only combinational path from resp_ready_i is to req_ready_o.
- Reset values: v1 = v2 = 0, resp_valid_o = 0, and all data registers are 0, so resp_value_o and resp_flags_o are 0. req_ready_o is 1 after reset.
- Reset asserted mid-flight discards all in-flight results. No partial response is produced.
- Simultaneous accept and drain when full: both happen in the same cycle with no bubble.

## Structure
- muntjac_fpu_pkg provides:
  - rounding_mode_e.
  - exception_flags_t.
  - a round-increment function (mode, sign, lsb, g, s).
- Sub-module: muntjac_fpu_right_shift (sticky-collecting shifter) for stage-1 denormalisation.
- Everything else stays in this module.

## Test plan
All cases use single precision.
- **Normal value:** sign 0, exp 0, sig 0, RNE → 0x3F800000, flags 0, resp_valid_o exactly 2 cycles after the accepting edge.
- **Rounding modes:** exp 0, frac 0x000001, g 1, s 0 gives:
  - RNE → 0x3F800002, NX.
  - RTZ → 0x3F800001, NX.
  - Same input with frac 0x000000, RNE → 0x3F800000 (tie to even).
- **Overflow:** exp 128, sign 0 gives:
  - RNE → 0x7F800000, OF|NX.
  - RTZ → 0x7F7FFFFF, OF|NX.
  - sign 1, RUP → 0xFF7FFFFF.
  - exp 127, frac all-ones, g 1, RNE → 0x7F800000, OF|NX.
- **Subnormal range:**
  - exp -127, sig 0 → 0x00400000, flags 0.
  - exp -150, sig 0, RNE → 0x00000000, UF|NX.
  - exp -150, sig 0, RUP → 0x00000001, UF|NX.
- **Specials:**
  - NaN with invalid 1 → 0x7FC00000, NV only.
  - sign 1, is_inf → 0xFF800000, flags 0.
  - sign 1, is_zero → 0x80000000, flags 0.
- **Handshake:**
  - Stream 4 requests back-to-back and hold resp_ready_i low 3 cycles → req_ready_o drops after 2 accepted, with no loss, duplication or reordering, and outputs stable while stalled.
  - Pulse rst_ni low with 2 in flight → resp_valid_o = 0 immediately, and no stale response after release.
